tri_sum_monitor: RTL and testbench
==================================

# tri_sum_monitor

Lockstep checker that sits directly downstream of the triangular-sum accumulator and consumes its `x`/`y` outputs and the `selector` strobe that drives it. It keeps an independent shadow model of the accumulator, compares the model against the observed values every cycle, and checks the safety property "y ≥ LIMIT implies x ≥ y". It reports completion, first-failure cause and failure time as sticky registered flags for the bench and for top-level status.

## Interface
- `W`, default 15: datapath width of `x`/`y`; all shadow arithmetic is modulo 2^W.
- `LIMIT`, default 300: step bound; the producer stops incrementing at `y == LIMIT`.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `selector`  input  1  same strobe that feeds the accumulator.
- `x_in`  input  W  accumulator `x` output.
- `y_in`  input  W  accumulator `y` output.
- `done`  output  1  shadow reached LIMIT with no failure.
- `fail`  output  1  sticky failure flag.
- `err_code`  output  2  cause of the first failure: 00 none, 01 x mismatch, 10 y mismatch, 11 property violation.
- `fail_cycle`  output  16  value of `cyc` at the failing comparison.
- `stall_cnt`  output  16  count of non-reset cycles in RUN with `selector == 0`; saturates at 0xFFFF.

## Operation
- Shadow registers `xs`/`ys` (W bits) and cycle counter `cyc` (16 bits, saturating at 0xFFFF).
- FSM states:
  - RUN (reset state).
  - DONE.
  - FAIL (absorbing until `rst`).
- Each non-reset cycle in RUN or DONE, the block compares the current inputs:
  - `prop = (y_in >= LIMIT) && (x_in < y_in)`.
  - `ym = (y_in != ys)`.
  - `xm = (x_in != xs)`.
  - Priority when several are true in the same cycle: prop (11) > ym (10) > xm (01).
- On any check hit:
  - Next state is FAIL.
  - `fail` is set to 1 and `err_code` to the highest-priority cause.
  - `fail_cycle` is loaded with `cyc`.
  - The shadow freezes.
- Otherwise, if `selector && ys < LIMIT`, the shadow updates: `xs <= xs + ys` (wraps mod 2^W), `ys <= ys + 1`. Else the shadow holds.
- RUN → DONE in the same cycle the shadow update makes `ys == LIMIT`, provided no check hit.
- DONE keeps comparing every cycle. A mismatch moves to FAIL and clears `done`.
- FAIL ignores all inputs. `err_code` and `fail_cycle` hold the first failure only.
- Wrap-around: with W=15 and LIMIT=300, the final x is 44851 mod 32768 = 12083. The shadow wraps identically, so wrap alone never fails.

## Timing
- Every output is registered.
- A check at cycle t is visible on `fail`/`err_code` at cycle t+1. `done` rises one cycle after the comparison cycle that produced the final step.
- `cyc` is 0 in the first cycle after `rst` deasserts and increments once per non-reset cycle.
- Reset values: `done=0`, `fail=0`, `err_code=00`, `fail_cycle=0`, `stall_cnt=0`. Internal reset values: `xs=1`, `ys=0`, `cyc=0`, state RUN.
- While `rst` is high, no comparison is made. The producer's stale pre-reset outputs are never checked.
- Reset mid-operation, in any state, restores all reset values on the next edge.
- Simultaneous final step and mismatch: FAIL wins; `done` stays 0.

## Configuration
- `TRI_MON_STALL_CNT_EN` defined: `stall_cnt` is implemented as described above.
- Not defined: the counter logic is omitted and `stall_cnt` is tied to 16'h0000. All other behaviour is unchanged.

## Test plan
- Reset 2 cycles, then `selector=1` continuously with a correct producer model → `done=1` one cycle after the 300th step, final `x_in=12083`, `fail=0`, `err_code=00`.
- Alternate `selector` 1/0 with a correct producer → `done` after 300 high cycles; `stall_cnt` equals the number of low cycles before DONE (299 with the define, 0 without).
- At `y_in=5`, drive `x_in=12` instead of the expected 11 → next cycle `fail=1`, `err_code=01`, `fail_cycle=5`. The flags stay sticky after `x_in` is corrected.
- At cyc 3, drive `y_in=300`, `x_in=10` → `err_code=11` (property beats y-mismatch), `fail_cycle=3`.
- Assert `rst` for 1 cycle while `y=100` → all outputs return to reset values; tracking restarts from x=1, y=0 with no false failure.
- In DONE, hold `selector=1` for 50 cycles with the producer holding x=12083, y=300 → `done` stays 1 and `fail` stays 0. Then drive `x_in=12084` → `done=0`, `fail=1`, `err_code=01`.

Source files
------------

// File: rtl/tri_sum_monitor_if.sv
// tri_sum_monitor_if: connects the triangular-sum accumulator, its
// selector strobe and the lockstep monitor outputs.
// There is no valid/ready pair. Every clock edge is one transfer and
// there is no backpressure. The producer presents selector/x_in/y_in,
// and the monitor samples them on every rising edge. The monitor outputs
// are registered, and each one is meaningful in every cycle.
interface tri_sum_monitor_if #(
  parameter int W = 15
);
  logic         selector;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic         done;
  logic         fail;
  logic [1:0]   err_code;
  logic [15:0]  fail_cycle;
  logic [15:0]  stall_cnt;
  logic [1:0]   dbg_state;

  // producer / bench side
  modport master (
    output selector, x_in, y_in,
    input  done, fail, err_code, fail_cycle, stall_cnt, dbg_state
  );

  // monitor side
  modport slave (
    input  selector, x_in, y_in,
    output done, fail, err_code, fail_cycle, stall_cnt, dbg_state
  );
endinterface

// File: rtl/tri_sum_monitor.sv
// tri_sum_monitor: lockstep checker for the triangular-sum accumulator.
// It keeps a shadow copy (xs, ys) of the accumulator and compares the
// shadow with the observed x/y in every cycle. It also checks the
// property "y >= LIMIT implies x >= y".
// The first failure is latched and held until rst.
// Optional feature macro: TRI_MON_STALL_CNT_EN. When it is defined, the
// block counts the RUN cycles that have selector low. When it is not
// defined, stall_cnt is tied to zero.
module tri_sum_monitor #(
  parameter int W     = 15,
  parameter int LIMIT = 300
) (
  input  logic               clk,
  input  logic               rst,
  tri_sum_monitor_if.slave   bus
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_DONE = 2'd1,
    S_FAIL = 2'd2
  } state_t;

  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);
  localparam logic [W-1:0] LAST_W  = W'(LIMIT - 1);

  state_t        state_q;
  logic [W-1:0]  xs_q;
  logic [W-1:0]  ys_q;
  logic [15:0]   cyc_q;
  logic          done_q;
  logic          fail_q;
  logic [1:0]    err_q;
  logic [15:0]   fcyc_q;

  logic          prop_hit;
  logic          y_mis;
  logic          x_mis;
  logic [1:0]    hit_code;
  logic          step_en;

  // Decode the check result. The property outranks a y mismatch, and a
  // y mismatch outranks an x mismatch.
  always_comb begin
    prop_hit = (bus.y_in >= LIMIT_W) && (bus.x_in < bus.y_in);
    y_mis    = (bus.y_in != ys_q);
    x_mis    = (bus.x_in != xs_q);
    hit_code = 2'b00;
    if (prop_hit)   hit_code = 2'b11;
    else if (y_mis) hit_code = 2'b10;
    else if (x_mis) hit_code = 2'b01;
    step_en  = bus.selector && (ys_q < LIMIT_W);
  end

  // Main FSM. It updates the shadow, the cycle counter and the sticky
  // status flags. FAIL is absorbing, so only rst leaves it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      xs_q    <= W'(1);
      ys_q    <= '0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      err_q   <= 2'b00;
      fcyc_q  <= '0;
    end else begin
      if (cyc_q != 16'hFFFF) cyc_q <= cyc_q + 16'd1;
      case (state_q)
        S_RUN, S_DONE: begin
          if (hit_code != 2'b00) begin
            state_q <= S_FAIL;
            fail_q  <= 1'b1;
            err_q   <= hit_code;
            fcyc_q  <= cyc_q;
            done_q  <= 1'b0;
          end else if (step_en) begin
            // the sum wraps modulo 2^W, which matches the producer
            xs_q <= xs_q + ys_q;
            ys_q <= ys_q + W'(1);
            if (ys_q == LAST_W) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TRI_MON_STALL_CNT_EN
  logic [15:0] stall_q;

  // Count the RUN cycles with selector low. The count saturates at 0xFFFF.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q == S_RUN && !bus.selector && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = 16'h0000;
`endif

  assign bus.done       = done_q;
  assign bus.fail       = fail_q;
  assign bus.err_code   = err_q;
  assign bus.fail_cycle = fcyc_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_tri_sum_monitor.sv
// tb_tri_sum_monitor: this bench drives a correct or faulty accumulator
// producer into tri_sum_monitor. It predicts every output from a
// closed-form reference model, in which x after k steps is
// 1 + k(k-1)/2 mod 2^W.
module tb_tri_sum_monitor;
  localparam int W     = 15;
  localparam int LIMIT = 300;
  localparam int OW    = 36;

`ifdef TRI_MON_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tri_sum_monitor_if #(.W(W)) bus ();

  tri_sum_monitor #(.W(W), .LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [OW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_k;      // steps the correct accumulator has taken
  int          m_cyc;
  bit          m_fail;
  bit          m_done;
  logic [1:0]  m_err;
  logic [15:0] m_fcyc;
  int          m_stall;
  int          pk;       // producer step count

  function automatic logic [W-1:0] tri_x(input int k);
    logic [31:0] v;
    v = 32'(1 + (k * (k - 1)) / 2);
    return v[W-1:0];
  endfunction

  function automatic logic [W-1:0] to_w(input int k);
    logic [31:0] v;
    v = 32'(k);
    return v[W-1:0];
  endfunction

  task automatic model_apply(input bit r, input bit s, input logic [W-1:0] x, input logic [W-1:0] y);
    int cause;
    logic [31:0] cv;
    if (r) begin
      m_k = 0; m_cyc = 0; m_fail = 0; m_done = 0;
      m_err = 2'b00; m_fcyc = 16'h0; m_stall = 0;
    end else begin
      if (!m_fail) begin
        cause = 0;
        if (int'(y) >= LIMIT && x < y) cause = 3;
        else if (y != to_w(m_k))       cause = 2;
        else if (x != tri_x(m_k))      cause = 1;
        if (STALL_EN && !m_done && !s && m_stall < 65535) m_stall++;
        if (cause != 0) begin
          m_fail = 1; m_done = 0;
          m_err  = 2'(cause);
          cv     = 32'(m_cyc);
          m_fcyc = cv[15:0];
        end else if (s && m_k < LIMIT) begin
          m_k++;
          if (m_k == LIMIT) m_done = 1;
        end
      end
      if (m_cyc < 65535) m_cyc++;
    end
    cv = 32'(m_stall);
    exp_q.push_back({m_done, m_fail, m_err, m_fcyc, cv[15:0]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit r, input bit s, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    rst = r; bus.selector = s; bus.x_in = x; bus.y_in = y;
    model_apply(r, s, x, y);
    @(posedge clk);
  endtask

  task automatic good(input bit s);
    drive(1'b0, s, tri_x(pk), to_w(pk));
    if (s && pk < LIMIT) pk++;
  endtask

  task automatic do_reset(input int n);
    repeat (n) drive(1'b1, 1'b0, tri_x(pk), to_w(pk));
    pk = 0;
  endtask

  task automatic run_to_done();
    int guard = 0;
    while (!m_done && guard < 1000) begin good(1'b1); guard++; end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [OW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs{done,fail,err,fail_cycle,stall}",
              {bus.done, bus.fail, bus.err_code, bus.fail_cycle, bus.stall_cnt}, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    logic [W-1:0] xf;
    bit s;
    bus.selector = 1'b0; bus.x_in = '0; bus.y_in = '0;
    pk = 0;

    // continuous selector, correct producer
    do_reset(2);
    #2;
    check("reset_fail", 36'(bus.fail), 36'(0));
    check("reset_done", 36'(bus.done), 36'(0));
    run_to_done();
    #2;
    check("s1_done", 36'(bus.done), 36'(1));
    check("s1_fail", 36'(bus.fail), 36'(0));
    check("s1_err",  36'(bus.err_code), 36'(0));

    // alternating selector
    do_reset(1);
    guard = 0;
    while (!m_done && guard < 1000) begin good(guard % 2 == 0); guard++; end
    #2;
    check("s2_done",  36'(bus.done), 36'(1));
    check("s2_stall", 36'(bus.stall_cnt), STALL_EN ? 36'(299) : 36'(0));

    // x mismatch at y=5
    do_reset(1);
    repeat (5) good(1'b1);
    drive(1'b0, 1'b1, to_w(12), to_w(5));
    pk++;
    #2;
    check("s3_fail", 36'(bus.fail), 36'(1));
    check("s3_err",  36'(bus.err_code), 36'(1));
    check("s3_fcyc", 36'(bus.fail_cycle), 36'(5));
    repeat (5) good(1'b1);
    #2;
    check("s3_sticky_err",  36'(bus.err_code), 36'(1));
    check("s3_sticky_fcyc", 36'(bus.fail_cycle), 36'(5));

    // property beats y mismatch at cyc 3
    do_reset(1);
    repeat (3) good(1'b1);
    drive(1'b0, 1'b1, to_w(10), to_w(300));
    repeat (3) good(1'b1);
    #2;
    check("s4_err",  36'(bus.err_code), 36'(3));
    check("s4_fcyc", 36'(bus.fail_cycle), 36'(3));

    // mid-run reset at y=100 with stale inputs
    do_reset(1);
    guard = 0;
    while (pk < 100 && guard < 1000) begin good(1'($urandom_range(0, 1))); guard++; end
    drive(1'b1, 1'b1, tri_x(pk), to_w(pk));
    pk = 0;
    #2;
    check("s5_rst_fail",  36'(bus.fail), 36'(0));
    check("s5_rst_fcyc",  36'(bus.fail_cycle), 36'(0));
    check("s5_rst_stall", 36'(bus.stall_cnt), 36'(0));
    repeat (20) good(1'b1);
    #2;
    check("s5_no_false_fail", 36'(bus.fail), 36'(0));

    // DONE holds, then an x mismatch
    do_reset(1);
    run_to_done();
    repeat (50) good(1'b1);
    #2;
    check("s6_done_hold", 36'(bus.done), 36'(1));
    check("s6_fail_hold", 36'(bus.fail), 36'(0));
    drive(1'b0, 1'b1, to_w(12084), to_w(300));
    #2;
    check("s6_done_clr", 36'(bus.done), 36'(0));
    check("s6_fail",     36'(bus.fail), 36'(1));
    check("s6_err",      36'(bus.err_code), 36'(1));

    // randomized selector with rare injected faults
    repeat (3) begin
      do_reset(1);
      for (int i = 0; i < 400; i++) begin
        s = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 99) == 0) begin
          xf = tri_x(pk) ^ (to_w(1) << $urandom_range(0, W - 1));
          drive(1'b0, s, xf, to_w(pk));
          if (s && pk < LIMIT) pk++;
        end else begin
          good(s);
        end
      end
    end

    @(posedge clk);
    #3;
    check("queue_drained", 36'(exp_q.size()), 36'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
